// File: rtl/score_keeper_if.sv
// Scoreboard bus: control/datapath inputs and score/win/display outputs.
// Clock and reset stay plain ports on the modules that use this bus.
interface score_keeper_if #(
    parameter int SCORE_W = 4
);
    logic               clear;
    logic               p0_point;
    logic               p1_point;
    logic [SCORE_W-1:0] p0_score;
    logic [SCORE_W-1:0] p1_score;
    logic [1:0]         winner;
    logic               restart;
    logic [6:0]         hex0;
    logic [6:0]         hex2;

    modport master (
        output clear, p0_point, p1_point,
        input  p0_score, p1_score, winner, restart, hex0, hex2
    );

    modport slave (
        input  clear, p0_point, p1_point,
        output p0_score, p1_score, winner, restart, hex0, hex2
    );
endinterface

// File: rtl/score_keeper.sv
// Two-player scoreboard: edge-counted points, win detect, restart request and
// blinking 7-segment score digits, all in the single clk domain.
//
//   state | meaning
//   PLAY  | match in progress, rising point edges increment scores
//   WON   | a score hit WIN_SCORE; scores frozen, restart high, winner blinks
module score_keeper #(
    parameter int WIN_SCORE = 2,
    parameter int SCORE_W   = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic           clk,
    input  logic           reset,
    score_keeper_if.slave  bus
);
    typedef enum logic {PLAY = 1'b0, WON = 1'b1} state_t;

    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    state_t             state_q, state_d;
    logic [SCORE_W-1:0] p0_score_q, p0_score_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [1:0]         winner_q, winner_d;
    logic               restart_q, restart_d;
    logic               p0_prev_q, p0_prev_d;
    logic               p1_prev_q, p1_prev_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_q, blink_d;
    logic [6:0]         hex0_q, hex0_d;
    logic [6:0]         hex2_q, hex2_d;
    logic               rise0, rise1, at_win0, at_win1;

    function automatic logic [6:0] seg7(input logic [3:0] v);
        case (v)
            4'h0: seg7 = 7'h40;
            4'h1: seg7 = 7'h79;
            4'h2: seg7 = 7'h24;
            4'h3: seg7 = 7'h30;
            4'h4: seg7 = 7'h19;
            4'h5: seg7 = 7'h12;
            4'h6: seg7 = 7'h02;
            4'h7: seg7 = 7'h78;
            4'h8: seg7 = 7'h00;
            4'h9: seg7 = 7'h10;
            4'hA: seg7 = 7'h08;
            4'hB: seg7 = 7'h03;
            4'hC: seg7 = 7'h46;
            4'hD: seg7 = 7'h21;
            4'hE: seg7 = 7'h06;
            default: seg7 = 7'h0E;
        endcase
    endfunction

    always_comb begin
        rise0       = bus.p0_point & ~p0_prev_q;
        rise1       = bus.p1_point & ~p1_prev_q;
        at_win0     = (p0_score_q == WIN_VAL);
        at_win1     = (p1_score_q == WIN_VAL);
        state_d     = state_q;
        p0_score_d  = p0_score_q;
        p1_score_d  = p1_score_q;
        winner_d    = winner_q;
        restart_d   = restart_q;
        blink_cnt_d = blink_cnt_q;
        blink_d     = blink_q;
        p0_prev_d   = bus.p0_point;
        p1_prev_d   = bus.p1_point;

        if (bus.clear) begin
            state_d     = PLAY;
            p0_score_d  = '0;
            p1_score_d  = '0;
            winner_d    = 2'b00;
            restart_d   = 1'b0;
            blink_cnt_d = '0;
            blink_d     = 1'b0;
        end else if (state_q == PLAY) begin
            // Once a score sits at WIN_SCORE the match is decided; no more points land.
            if (at_win0 || at_win1) begin
                state_d   = WON;
                winner_d  = {at_win1, at_win0};
                restart_d = 1'b1;
            end else begin
                if (rise0) p0_score_d = p0_score_q + 1'b1;
                if (rise1) p1_score_d = p1_score_q + 1'b1;
            end
        end else begin
            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        hex0_d = (blink_q && winner_q[0]) ? 7'h7F : seg7(4'(p0_score_q));
        hex2_d = (blink_q && winner_q[1]) ? 7'h7F : seg7(4'(p1_score_q));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= PLAY;
            p0_score_q  <= '0;
            p1_score_q  <= '0;
            winner_q    <= 2'b00;
            restart_q   <= 1'b0;
            p0_prev_q   <= 1'b1;
            p1_prev_q   <= 1'b1;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
            hex0_q      <= 7'h40;
            hex2_q      <= 7'h40;
        end else begin
            state_q     <= state_d;
            p0_score_q  <= p0_score_d;
            p1_score_q  <= p1_score_d;
            winner_q    <= winner_d;
            restart_q   <= restart_d;
            p0_prev_q   <= p0_prev_d;
            p1_prev_q   <= p1_prev_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
            hex0_q      <= hex0_d;
            hex2_q      <= hex2_d;
        end
    end

    assign bus.p0_score = p0_score_q;
    assign bus.p1_score = p1_score_q;
    assign bus.winner   = winner_q;
    assign bus.restart  = restart_q;
    assign bus.hex0     = hex0_q;
    assign bus.hex2     = hex2_q;
endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper with WIN_SCORE=2 and BLINK_DIV=4 so blinking
// is observable in a few cycles.
module tb_score_keeper;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    score_keeper_if #(.SCORE_W(4)) bus ();

    score_keeper #(
        .WIN_SCORE(2),
        .SCORE_W  (4),
        .BLINK_DIV(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.clear    = 1'b0;
        bus.p0_point = 1'b1;
        bus.p1_point = 1'b0;
        tick();
        tick();
        check("rst_p0_score", 32'(bus.p0_score), 32'd0);
        check("rst_p1_score", 32'(bus.p1_score), 32'd0);
        check("rst_winner",   32'(bus.winner),   32'd0);
        check("rst_restart",  32'(bus.restart),  32'd0);
        check("rst_hex0",     32'(bus.hex0),     32'h40);
        check("rst_hex2",     32'(bus.hex2),     32'h40);

        // p0 held high across reset release must not count
        reset = 1'b0;
        tick();
        tick();
        tick();
        check("held_p0_no_count", 32'(bus.p0_score), 32'd0);
        bus.p0_point = 1'b0;
        tick();
        bus.p0_point = 1'b1;
        tick();
        check("p0_pulse_score", 32'(bus.p0_score), 32'd1);
        bus.p0_point = 1'b0;
        tick();
        check("p0_hex0_one", 32'(bus.hex0), 32'h79);

        // long p1 level counts exactly once
        bus.p1_point = 1'b1;
        for (int i = 0; i < 50; i++) tick();
        check("p1_level_once", 32'(bus.p1_score), 32'd1);
        bus.p1_point = 1'b0;
        tick();
        check("p1_hex2_one", 32'(bus.hex2), 32'h79);

        // simultaneous final points: draw
        bus.p0_point = 1'b1;
        bus.p1_point = 1'b1;
        tick();
        check("draw_p0_score", 32'(bus.p0_score), 32'd2);
        check("draw_p1_score", 32'(bus.p1_score), 32'd2);
        check("draw_winner_lag", 32'(bus.winner), 32'd0);
        bus.p0_point = 1'b0;
        bus.p1_point = 1'b0;
        tick();
        check("draw_winner",  32'(bus.winner),  32'd3);
        check("draw_restart", 32'(bus.restart), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            tick();
            check("draw_blink_hex0", 32'(bus.hex0), (k >= 5 && k <= 8) ? 32'h7F : 32'h24);
            check("draw_blink_hex2", 32'(bus.hex2), (k >= 5 && k <= 8) ? 32'h7F : 32'h24);
        end

        bus.clear = 1'b1;
        tick();
        check("clr_p0_score", 32'(bus.p0_score), 32'd0);
        check("clr_p1_score", 32'(bus.p1_score), 32'd0);
        check("clr_winner",   32'(bus.winner),   32'd0);
        check("clr_restart",  32'(bus.restart),  32'd0);
        bus.clear = 1'b0;
        tick();
        check("clr_hex0", 32'(bus.hex0), 32'h40);

        // p0 wins outright; loser digit steady, extra points ignored
        bus.p0_point = 1'b1;
        tick();
        bus.p0_point = 1'b0;
        tick();
        bus.p0_point = 1'b1;
        tick();
        check("win_p0_score", 32'(bus.p0_score), 32'd2);
        check("win_winner_lag", 32'(bus.winner), 32'd0);
        bus.p0_point = 1'b0;
        tick();
        check("win_winner",  32'(bus.winner),  32'd1);
        check("win_restart", 32'(bus.restart), 32'd1);
        for (int k = 1; k <= 12; k++) begin
            bus.p0_point = (k == 2);
            bus.p1_point = (k == 3);
            tick();
            check("win_blink_hex0", 32'(bus.hex0), (k >= 5 && k <= 8) ? 32'h7F : 32'h24);
            check("win_steady_hex2", 32'(bus.hex2), 32'h40);
            check("win_p0_frozen", 32'(bus.p0_score), 32'd2);
            check("win_p1_frozen", 32'(bus.p1_score), 32'd0);
        end
        bus.p0_point = 1'b0;
        bus.p1_point = 1'b0;

        bus.clear = 1'b1;
        tick();
        check("wonclr_restart", 32'(bus.restart),  32'd0);
        check("wonclr_winner",  32'(bus.winner),   32'd0);
        check("wonclr_p0",      32'(bus.p0_score), 32'd0);
        bus.clear = 1'b0;
        tick();

        // clear beats a simultaneous rise; prev still tracks during clear
        bus.clear    = 1'b1;
        bus.p1_point = 1'b1;
        tick();
        check("clr_rise_dropped", 32'(bus.p1_score), 32'd0);
        bus.clear = 1'b0;
        tick();
        check("clr_prev_tracked", 32'(bus.p1_score), 32'd0);
        bus.p1_point = 1'b0;
        tick();
        bus.p1_point = 1'b1;
        tick();
        check("post_clr_p1", 32'(bus.p1_score), 32'd1);
        bus.p1_point = 1'b0;
        tick();

        // asynchronous reset mid-match
        bus.p0_point = 1'b1;
        tick();
        bus.p0_point = 1'b0;
        tick();
        check("pre_arst_p0", 32'(bus.p0_score), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_p0_score", 32'(bus.p0_score), 32'd0);
        check("arst_p1_score", 32'(bus.p1_score), 32'd0);
        check("arst_hex0",     32'(bus.hex0),     32'h40);
        check("arst_hex2",     32'(bus.hex2),     32'h40);
        tick();
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
